uart_cmd_bridge: RTL

//  Register-access bridge on the host side of the uart FIFO ports: reads command

---
 rtl/uart_cmd_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bridge.sv
// Host-side register-access bridge: decodes write/read commands from the uart rx FIFO,
// runs one bus transaction and returns a one-byte response through the tx FIFO.
module uart_cmd_bridge #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned RX_TIMEOUT  = 100000,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    output logic                  rx_read,
    output logic [7:0]            tx_data,
    output logic                  tx_write,
    input  logic                  tx_full,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack
);

    localparam int unsigned RXW = $clog2(RX_TIMEOUT + 1);
    localparam int unsigned BSW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [RXW-1:0] RX_LIMIT = RXW'(RX_TIMEOUT);
    localparam logic [BSW-1:0] BUS_LAST = BSW'(BUS_TIMEOUT - 1);
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RESP
    } state_t;

    state_t                r_state, w_state;
    logic                  r_rx_read, w_rx_read;
    logic                  r_req, w_req;
    logic                  r_is_wr, w_is_wr;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [7:0]            r_wdata, w_wdata;
    logic [7:0]            r_resp, w_resp;
    logic [RXW-1:0]        r_rx_cnt, w_rx_cnt;
    logic [BSW-1:0]        r_bus_cnt, w_bus_cnt;
    logic                  w_fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_read <= 1'b0;
            r_req     <= 1'b0;
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_resp    <= '0;
            r_rx_cnt  <= '0;
            r_bus_cnt <= '0;
        end else begin
            r_rx_read <= w_rx_read;
            r_req     <= w_req;
            r_is_wr   <= w_is_wr;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_resp    <= w_resp;
            r_rx_cnt  <= w_rx_cnt;
            r_bus_cnt <= w_bus_cnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_rx_read = 1'b0;
        w_req     = r_req;
        w_is_wr   = r_is_wr;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_resp    = r_resp;
        w_rx_cnt  = r_rx_cnt;
        w_bus_cnt = r_bus_cnt;
        // The pop lands one cycle after capture, so the head is stale while rx_read is high.
        w_fetch   = !rx_empty && !r_rx_read &&
                    (r_state == S_IDLE || r_state == S_GET_ADDR || r_state == S_GET_DATA);

        unique case (r_state)
            S_IDLE: begin
                w_rx_cnt  = '0;
                w_bus_cnt = '0;
                w_req     = 1'b0;
                if (w_fetch) begin
                    w_rx_read = 1'b1;
                    if (rx_data == OP_WR) begin
                        w_is_wr = 1'b1;
                        w_state = S_GET_ADDR;
                    end else if (rx_data == OP_RD) begin
                        w_is_wr = 1'b0;
                        w_state = S_GET_ADDR;
                    end else begin
                        w_resp  = RSP_NAK;
                        w_state = S_RESP;
                    end
                end
            end
            S_GET_ADDR: begin
                if (w_fetch) begin
                    w_rx_read = 1'b1;
                    w_rx_cnt  = '0;
                    w_addr    = rx_data[ADDR_WIDTH-1:0];
                    w_state   = r_is_wr ? S_GET_DATA : S_BUS_RD;
                end else if (r_rx_cnt == RX_LIMIT) begin
                    w_state = S_IDLE;
                end else begin
                    w_rx_cnt = r_rx_cnt + 1'b1;
                end
            end
            S_GET_DATA: begin
                if (w_fetch) begin
                    w_rx_read = 1'b1;
                    w_rx_cnt  = '0;
                    w_wdata   = rx_data;
                    w_state   = S_BUS_WR;
                end else if (r_rx_cnt == RX_LIMIT) begin
                    w_state = S_IDLE;
                end else begin
                    w_rx_cnt = r_rx_cnt + 1'b1;
                end
            end
            S_BUS_WR, S_BUS_RD: begin
                // First cycle only raises the request; acks count once it is visible.
                if (!r_req) begin
                    w_req     = 1'b1;
                    w_bus_cnt = '0;
                end else if (bus_ack) begin
                    w_req   = 1'b0;
                    w_resp  = (r_state == S_BUS_WR) ? RSP_ACK : bus_rdata;
                    w_state = S_RESP;
                end else if (r_bus_cnt == BUS_LAST) begin
                    w_req   = 1'b0;
                    w_resp  = RSP_NAK;
                    w_state = S_RESP;
                end else begin
                    w_bus_cnt = r_bus_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (!tx_full) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign rx_read   = r_rx_read;
    assign bus_we    = r_req & r_is_wr;
    assign bus_re    = r_req & ~r_is_wr;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign tx_data   = r_resp;
    assign tx_write  = (r_state == S_RESP) & ~tx_full;

endmodule
